// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVENT_W = $bits(ps2_event_t);

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO holding decoded key events; valid/ready pop side.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    // Pointer/count update; a pop in the same cycle frees a slot for a push into a full FIFO.
    always_comb begin
        do_pop   = pop_ready && (cnt_q != '0);
        full     = (cnt_q == DEPTH_C);
        do_push  = push_valid && (!full || do_pop);
        ovf_d    = push_valid && full && !do_pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_valid = (cnt_q != '0);
    assign pop_data  = pop_valid ? mem_q[rd_ptr_q] : '0;
    assign ovf       = ovf_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: input filtering, frame FSM with watchdog, E0/F0 decode,
// event FIFO and held-key levels for the jump and duck keys.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN  = 4,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] JUMP_CODE   = 8'h29,
    parameter logic [7:0] DUCK_CODE   = 8'h72
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       KB_clk,
    input  logic       KB_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] code,
    output logic       key_jump,
    output logic       key_duck,
    output logic       frame_err,
    output logic       fifo_ovf
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [WW-1:0]  WD_LAST   = WW'(TIMEOUT_CYC - 1);

    // Synchroniser and filter state
    logic           kclk_s1_q, kclk_s1_d, kclk_s2_q, kclk_s2_d;
    logic           kdat_s1_q, kdat_s1_d, kdat_s2_q, kdat_s2_d;
    logic           kclk_f_q, kclk_f_d, kdat_f_q, kdat_f_d;
    logic [FCW-1:0] kclk_cnt_q, kclk_cnt_d, kdat_cnt_q, kdat_cnt_d;
    logic           sample;

    // Frame FSM and watchdog
    ps2_state_e     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic           stb_q, stb_d;
    logic           err_q, err_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic           timeout;

    // Decoder
    logic           ext_q, ext_d, brk_q, brk_d;
    logic [7:0]     code_q, code_d;
    logic           jump_q, jump_d, duck_q, duck_d;
    logic           push;
    ps2_event_t     push_ev, head_ev;
    logic           fifo_full;

    // Two-flop synchroniser followed by a run-length filter on each PS/2 line.
    always_comb begin
        kclk_s1_d  = KB_clk;
        kclk_s2_d  = kclk_s1_q;
        kdat_s1_d  = KB_data;
        kdat_s2_d  = kdat_s1_q;
        kclk_f_d   = kclk_f_q;
        kclk_cnt_d = '0;
        kdat_f_d   = kdat_f_q;
        kdat_cnt_d = '0;
        if (kclk_s2_q != kclk_f_q) begin
            if (kclk_cnt_q == FILT_LAST) kclk_f_d = kclk_s2_q;
            else                         kclk_cnt_d = kclk_cnt_q + 1'b1;
        end
        if (kdat_s2_q != kdat_f_q) begin
            if (kdat_cnt_q == FILT_LAST) kdat_f_d = kdat_s2_q;
            else                         kdat_cnt_d = kdat_cnt_q + 1'b1;
        end
        // Data is stable across the filtered clock's falling edge, so kdat_f_q is the bit.
        sample = kclk_f_q && !kclk_f_d;
    end

    // Frame FSM next-state, bit assembly and watchdog.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        stb_d     = 1'b0;
        err_d     = 1'b0;
        wd_d      = (sample || state_q == IDLE) ? '0 : wd_q + 1'b1;
        timeout   = (state_q != IDLE) && !sample && (wd_q == WD_LAST);
        unique case (state_q)
            IDLE: begin
                if (sample && !kdat_f_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_d   = {kdat_f_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (sample) begin
                    par_d   = kdat_f_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (kdat_f_q && ps2_parity_ok(shreg_q, par_q)) stb_d = 1'b1;
                    else                                           err_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // Prefix folding, event generation and held-key tracking on each received byte.
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        jump_d  = jump_q;
        duck_d  = duck_q;
        push    = 1'b0;
        push_ev = '{ext: ext_q, brk: brk_q, code: shreg_q};
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (stb_q) begin
            if (shreg_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!brk_q)                 code_d = shreg_q;
                else if (shreg_q == code_q) code_d = 8'h00;
                if (!ext_q && shreg_q == JUMP_CODE) jump_d = !brk_q;
                if (ext_q && shreg_q == DUCK_CODE)  duck_d = !brk_q;
            end
        end
    end

    // Control registers; filters and synchronisers preset to the idle-high line level.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            kclk_s1_q  <= 1'b1;
            kclk_s2_q  <= 1'b1;
            kdat_s1_q  <= 1'b1;
            kdat_s2_q  <= 1'b1;
            kclk_f_q   <= 1'b1;
            kdat_f_q   <= 1'b1;
            kclk_cnt_q <= '0;
            kdat_cnt_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            stb_q      <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            code_q     <= 8'h00;
            jump_q     <= 1'b0;
            duck_q     <= 1'b0;
        end else begin
            kclk_s1_q  <= kclk_s1_d;
            kclk_s2_q  <= kclk_s2_d;
            kdat_s1_q  <= kdat_s1_d;
            kdat_s2_q  <= kdat_s2_d;
            kclk_f_q   <= kclk_f_d;
            kdat_f_q   <= kdat_f_d;
            kclk_cnt_q <= kclk_cnt_d;
            kdat_cnt_q <= kdat_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stb_q      <= stb_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            code_q     <= code_d;
            jump_q     <= jump_d;
            duck_q     <= duck_d;
        end
    end

    // Datapath registers for the byte being assembled.
    always_ff @(posedge VGA_clk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

    ps2_event_fifo #(
        .WIDTH (PS2_EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (VGA_clk),
        .reset      (reset),
        .push_valid (push),
        .push_data  (push_ev),
        .pop_ready  (ev_ready),
        .pop_valid  (ev_valid),
        .pop_data   (head_ev),
        .full       (fifo_full),
        .ovf        (fifo_ovf)
    );

    assign ev_code   = head_ev.code;
    assign ev_ext    = head_ev.ext;
    assign ev_break  = head_ev.brk;
    assign code      = code_q;
    assign key_jump  = jump_q;
    assign key_duck  = duck_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: hand-built PS/2 frames, expected events by hand.
module tb_ps2_scancode_rx;

    localparam int H  = 10;   // PS/2 half period in VGA_clk cycles
    localparam int TO = 400;  // shortened watchdog for simulation

    logic       VGA_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       KB_clk  = 1'b1;
    logic       KB_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, key_jump, key_duck, frame_err, fifo_ovf;
    logic [7:0] ev_code, code;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int e0, o0;

    ps2_scancode_rx #(
        .FILTER_LEN  (4),
        .TIMEOUT_CYC (TO),
        .FIFO_DEPTH  (4),
        .JUMP_CODE   (8'h29),
        .DUCK_CODE   (8'h72)
    ) dut (
        .VGA_clk   (VGA_clk),
        .reset     (reset),
        .KB_clk    (KB_clk),
        .KB_data   (KB_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .code      (code),
        .key_jump  (key_jump),
        .key_duck  (key_duck),
        .frame_err (frame_err),
        .fifo_ovf  (fifo_ovf)
    );

    always #5 VGA_clk = ~VGA_clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge VGA_clk) begin
        if (frame_err) err_cnt++;
        if (fifo_ovf)  ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge VGA_clk);
    endtask

    task automatic send_bit(input logic b);
        KB_data = b;
        cycles(H);
        KB_clk = 1'b0;
        cycles(H);
        KB_clk = 1'b1;
    endtask

    // Sends the first nbits of an 11-bit frame (11 = complete frame).
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        KB_data = 1'b1;
        cycles(2 * H);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic pop_expect(input string tag, input logic e, input logic k, input logic [7:0] c);
        check({tag, "_valid"}, ev_valid, 1);
        check(tag, {ev_ext, ev_break, ev_code}, {e, k, c});
        ev_ready = 1'b1;
        cycles(1);
        ev_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {ev_valid, ev_ext, ev_break, ev_code, code, key_jump, key_duck, frame_err, fifo_ovf}, 0);
    endtask

    initial begin
        cycles(3);
        reset = 1'b0;
        cycles(2);
        check_all_zero("reset_outputs");

        // 1: single make of the jump key
        send(8'h29);
        check("t1_jump", key_jump, 1);
        check("t1_code", code, 8'h29);
        pop_expect("t1_ev", 0, 0, 8'h29);
        check("t1_empty", ev_valid, 0);

        // 2: break of the jump key
        send(8'hF0);
        check("t2_no_f0_ev", ev_valid, 0);
        send(8'h29);
        pop_expect("t2_ev", 0, 1, 8'h29);
        check("t2_jump", key_jump, 0);
        check("t2_code", code, 8'h00);

        // 3: extended duck key with jump held
        send(8'h29);
        pop_expect("t3_jmake", 0, 0, 8'h29);
        send(8'hE0);
        check("t3_no_e0_ev", ev_valid, 0);
        send(8'h72);
        pop_expect("t3_dmake", 1, 0, 8'h72);
        check("t3_duck1", key_duck, 1);
        check("t3_jump1", key_jump, 1);
        check("t3_code1", code, 8'h72);
        send(8'hE0);
        send(8'hF0);
        send(8'h72);
        pop_expect("t3_dbreak", 1, 1, 8'h72);
        check("t3_duck0", key_duck, 0);
        check("t3_jump_kept", key_jump, 1);
        check("t3_code0", code, 8'h00);

        // 4: parity error then good frame
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 11);
        check("t4_err", err_cnt - e0, 1);
        check("t4_no_ev", ev_valid, 0);
        send(8'h1C);
        check("t4_err_once", err_cnt - e0, 1);
        pop_expect("t4_ev", 0, 0, 8'h1C);
        check("t4_code", code, 8'h1C);

        // 5: overflow with consumer stalled
        o0 = ovf_cnt;
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        send(8'h2D);
        check("t5_no_ovf", ovf_cnt - o0, 0);
        send(8'h2C);
        check("t5_ovf", ovf_cnt - o0, 1);
        check("t5_code_upd", code, 8'h2C);
        pop_expect("t5_pop0", 0, 0, 8'h15);
        pop_expect("t5_pop1", 0, 0, 8'h1D);
        pop_expect("t5_pop2", 0, 0, 8'h24);
        pop_expect("t5_pop3", 0, 0, 8'h2D);
        check("t5_empty", ev_valid, 0);

        // 6: timeout clears a pending E0, then recovery and reset mid-frame
        e0 = err_cnt;
        send(8'hE0);
        send_frame(8'h5A, 1'b0, 5);
        check("t6_no_err_yet", err_cnt - e0, 0);
        cycles(TO + 50);
        check("t6_timeout", err_cnt - e0, 1);
        check("t6_no_ev", ev_valid, 0);
        send(8'h72);
        pop_expect("t6_plain72", 0, 0, 8'h72);
        check("t6_duck", key_duck, 0);
        send(8'h29);
        check("t6_valid", ev_valid, 1);
        check("t6_code", code, 8'h29);
        send_frame(8'h29, 1'b0, 3);
        reset = 1'b1;
        cycles(1);
        check_all_zero("t6_reset_mid");
        reset = 1'b0;
        cycles(TO + 50);
        check_all_zero("t6_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
